// File: rtl/regfile_pkg.sv
// Shared widths and helpers for the scoreboarded register file.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;

  // Widest flattened bus and widest field the helpers accept.
  localparam int RF_BUS_MAX  = 1024;
  localparam int RF_FIELD_MAX = 64;

  // Largest scoreboard the popcount helper covers, and its result width.
  localparam int RF_MAX_REGS = 256;
  localparam int RF_CNT_W    = 9;

  // Field k of width w from a flattened bus; caller truncates to w bits.
  function automatic logic [RF_FIELD_MAX-1:0] rf_field(
    input logic [RF_BUS_MAX-1:0] bus,
    input int                    k,
    input int                    w
  );
    return RF_FIELD_MAX'(bus >> (k * w));
  endfunction

  // Number of set bits, used for the busy-register count.
  function automatic logic [RF_CNT_W-1:0] rf_popcount(
    input logic [RF_MAX_REGS-1:0] v
  );
    logic [RF_CNT_W-1:0] cnt;
    cnt = '0;
    for (int b = 0; b < RF_MAX_REGS; b++) begin
      cnt = cnt + RF_CNT_W'(v[b]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: stored value, overridden by highest-index same-cycle write; zero-reg and reset force 0.
// Latency: purely combinational.
// Backpressure: none; rbusy reports a pending producer that this cycle's writeback does not resolve.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     res,
  input  logic [ADDR_W-1:0]        ra,
  input  logic [DATA_W-1:0]        reg_val,
  input  logic                     busy_bit,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_reg,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rbusy
);

  logic hit;

  // Priority match across write ports (later port wins), then zero-reg and reset overrides.
  always_comb begin
    rdata = reg_val;
    hit   = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (ADDR_W'(rf_field(RF_BUS_MAX'(wr_reg), j, ADDR_W)) == ra)) begin
        rdata = DATA_W'(rf_field(RF_BUS_MAX'(wr_data), j, DATA_W));
        hit   = 1'b1;
      end
    end
    rbusy = busy_bit & ~hit;
    if ((ZERO_REG != 0) && (ra == '0)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
    if (!res) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and an issue/writeback busy scoreboard.
// Latency: reads and rbusy/stall are combinational; writes, busy bits and busy_cnt update at the edge.
// Backpressure: stall is raised while any read port sources a register with an unresolved producer.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_reg,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_reg,
  output logic                     stall,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W-1:0] wr_addr [NUM_WR];
  logic [DATA_W-1:0] wr_val  [NUM_WR];

  // Unpack the flattened write buses into per-port fields.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_addr[j] = ADDR_W'(rf_field(RF_BUS_MAX'(wr_reg), j, ADDR_W));
      wr_val[j]  = DATA_W'(rf_field(RF_BUS_MAX'(wr_data), j, DATA_W));
    end
  end

  // Next scoreboard: writebacks clear, issue sets afterwards so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_nxt[wr_addr[j]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_nxt[iss_reg] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // Storage, scoreboard and busy count; later write ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (!res) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j] == '0))) begin
          regs[wr_addr[j]] <= wr_val[j];
        end
      end
      busy     <= busy_nxt;
      busy_cnt <= (ADDR_W+1)'(rf_popcount(RF_MAX_REGS'(busy_nxt)));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra_i;
      logic [DATA_W-1:0] reg_val_i;
      logic              busy_i;

      assign ra_i      = ra[gi*ADDR_W +: ADDR_W];
      assign reg_val_i = regs[ra_i];
      assign busy_i    = busy[ra_i];

      regfile_bypass_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG)
      ) u_mux (
        .res     (res),
        .ra      (ra_i),
        .reg_val (reg_val_i),
        .busy_bit(busy_i),
        .wr_en   (wr_en),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .rdata   (rdata[gi*DATA_W +: DATA_W]),
        .rbusy   (rbusy[gi])
      );
    end
  endgenerate

  assign stall = |rbusy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters.
// Latency: checks combinational reads #1 after driving, registered state #1 after the edge.
// Backpressure: stall/rbusy checked against hand-derived hazard state.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                     clk;
  logic                     res;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_reg;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_reg;
  logic                     stall;
  logic [ADDR_W:0]          busy_cnt;

  int n_cmp;
  int n_err;

  regfile_sb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(1)
  ) dut (
    .clk     (clk),
    .res     (res),
    .ra      (ra),
    .rdata   (rdata),
    .rbusy   (rbusy),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .iss_en  (iss_en),
    .iss_reg (iss_reg),
    .stall   (stall),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_wr(input int j, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    wr_en[j] = 1'b1;
    wr_reg[j*ADDR_W +: ADDR_W] = r;
    wr_data[j*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle_in();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic set_ra(input int i, input logic [ADDR_W-1:0] r);
    ra[i*ADDR_W +: ADDR_W] = r;
  endtask

  function automatic logic [DATA_W-1:0] rd(input int i);
    return rdata[i*DATA_W +: DATA_W];
  endfunction

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    res     = 1'b0;
    ra      = '0;
    wr_en   = '0;
    wr_reg  = '0;
    wr_data = '0;
    iss_en  = 1'b0;
    iss_reg = '0;

    // 1: writes and an issue while reset is held are ignored; outputs forced to 0
    set_wr(0, 5'd3, 32'd42);
    iss_en  = 1'b1;
    iss_reg = 5'd3;
    set_ra(0, 5'd3);
    settle();
    chk("rst_rdata_bypass_off", 64'(rd(0)), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    tick();
    tick();
    chk("rst_rdata", 64'(rd(0)), 64'd0);
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_rbusy0", 64'(rbusy[0]), 64'd0);
    idle_in();
    res = 1'b1;
    settle();
    chk("post_rst_r3", 64'(rd(0)), 64'd0);
    chk("post_rst_stall", 64'(stall), 64'd0);

    // 2: write-through bypass, then stored value
    set_wr(0, 5'd18, 32'd42);
    set_ra(0, 5'd18);
    settle();
    chk("bypass_r18", 64'(rd(0)), 64'd42);
    tick();
    idle_in();
    settle();
    chk("stored_r18", 64'(rd(0)), 64'd42);

    // 3: both ports write r11, port 1 wins
    set_wr(0, 5'd11, 32'd4);
    set_wr(1, 5'd11, 32'd7);
    set_ra(1, 5'd11);
    settle();
    chk("prio_bypass_r11", 64'(rd(1)), 64'd7);
    tick();
    idle_in();
    settle();
    chk("prio_stored_r11", 64'(rd(1)), 64'd7);

    // 4: issue r9, hazard seen, same-cycle writeback resolves it
    iss_en  = 1'b1;
    iss_reg = 5'd9;
    tick();
    idle_in();
    set_ra(1, 5'd9);
    settle();
    chk("iss_rbusy1", 64'(rbusy[1]), 64'd1);
    chk("iss_stall", 64'(stall), 64'd1);
    chk("iss_busy_cnt", 64'(busy_cnt), 64'd1);
    set_wr(0, 5'd9, 32'd5);
    settle();
    chk("wb_rbusy1", 64'(rbusy[1]), 64'd0);
    chk("wb_stall", 64'(stall), 64'd0);
    chk("wb_bypass_r9", 64'(rd(1)), 64'd5);
    tick();
    idle_in();
    settle();
    chk("wb_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("wb_stored_r9", 64'(rd(1)), 64'd5);

    // plain write to an idle register stays idle
    set_wr(1, 5'd9, 32'd1);
    tick();
    idle_in();
    settle();
    chk("idle_wr_r9", 64'(rd(1)), 64'd1);
    chk("idle_wr_cnt", 64'(busy_cnt), 64'd0);

    // 5: write and re-issue r9 together while busy: data lands, busy stays
    iss_en  = 1'b1;
    iss_reg = 5'd9;
    tick();
    chk("re_busy_cnt", 64'(busy_cnt), 64'd1);
    set_wr(0, 5'd9, 32'd5);
    settle();
    chk("both_rbusy1_comb", 64'(rbusy[1]), 64'd0);
    tick();
    idle_in();
    settle();
    chk("both_r9", 64'(rd(1)), 64'd5);
    chk("both_rbusy1", 64'(rbusy[1]), 64'd1);
    chk("both_busy_cnt", 64'(busy_cnt), 64'd1);

    // double issue does not count twice
    iss_en  = 1'b1;
    iss_reg = 5'd9;
    tick();
    idle_in();
    chk("dbl_busy_cnt", 64'(busy_cnt), 64'd1);
    set_wr(1, 5'd9, 32'd6);
    tick();
    idle_in();
    settle();
    chk("dbl_clear_cnt", 64'(busy_cnt), 64'd0);
    chk("dbl_clear_rbusy1", 64'(rbusy[1]), 64'd0);

    // 6: register 0 ignores writes, bypass and issue
    set_ra(0, 5'd0);
    set_wr(1, 5'd0, 32'd99);
    iss_en  = 1'b1;
    iss_reg = 5'd0;
    settle();
    chk("r0_no_bypass", 64'(rd(0)), 64'd0);
    tick();
    idle_in();
    settle();
    chk("r0_rdata", 64'(rd(0)), 64'd0);
    chk("r0_rbusy0", 64'(rbusy[0]), 64'd0);
    chk("r0_busy_cnt", 64'(busy_cnt), 64'd0);

    // multiple busy registers, then reset mid-operation discards them
    iss_en  = 1'b1;
    iss_reg = 5'd5;
    tick();
    iss_reg = 5'd6;
    tick();
    idle_in();
    set_ra(0, 5'd5);
    set_ra(1, 5'd18);
    settle();
    chk("multi_busy_cnt", 64'(busy_cnt), 64'd2);
    chk("multi_rbusy0", 64'(rbusy[0]), 64'd1);
    res = 1'b0;
    settle();
    chk("midrst_rdata1", 64'(rd(1)), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    tick();
    res = 1'b1;
    settle();
    chk("midrst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("midrst_rbusy0", 64'(rbusy[0]), 64'd0);
    chk("midrst_r18_cleared", 64'(rd(1)), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
